ads5296_tx_emulator: RTL

Emulates the data side of one ADS5296 lane pair for loopback and bench testing of the ADS5296 deserializer path. Takes 10-bit samples for two lanes at one word per five line-clock cycles and serializes them LSB-first as rise/fall bit pairs, two bits per lane per cycle. Also generates the matching frame pattern. Sits in front of the per-unit deserializer, either in simulation or driving ODDR primitives in a loopback build. It optionally substitutes on-chip ADC test patterns.

---
 rtl/ads5296_pkg.sv | 20 ++
 rtl/ads5296_tx_lane.sv | 40 ++++
 rtl/ads5296_tx_emulator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ads5296_pkg.sv
// rtl/ads5296_pkg.sv - shared constants, mode encoding and widths for the ADS5296 TX emulator
package ads5296_pkg;

   localparam int WORD_W = 10;
   localparam int PHASES = 5;

   localparam logic [2:0] LOAD_PHASE = 3'(PHASES - 1);

   localparam logic [WORD_W-1:0] FCLK_PATTERN   = 10'b1111100000;
   localparam logic [WORD_W-1:0] DESKEW_PATTERN = 10'b0101010101;
   localparam logic [WORD_W-1:0] SYNC_PATTERN   = 10'b1111100000;

   typedef enum logic [1:0] {
      DATA   = 2'd0,
      RAMP   = 2'd1,
      DESKEW = 2'd2,
      SYNC   = 2'd3
   } mode_e;

endpackage

// File: rtl/ads5296_tx_lane.sv
// rtl/ads5296_tx_lane.sv - 10-bit word register emitting the registered rise/fall pair of the next phase
module ads5296_tx_lane
   import ads5296_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        phase_next,
   input  logic              load,
   input  logic [WORD_W-1:0] load_word,
   output logic              rise,
   output logic              fall
);

   logic [WORD_W-1:0] word;
   logic [WORD_W-1:0] word_next;
   logic [3:0]        bit_idx;

   // The pair registered at this edge belongs to the phase the counter moves into,
   // so a word loaded now shows its bit pair 0 on the very next cycle.
   always_comb begin
      word_next = load ? load_word : word;
      bit_idx   = {phase_next, 1'b0};
   end

   // Hold the word and register the selected pair; reset drops any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word <= RESET_WORD;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         word <= word_next;
         rise <= word_next[bit_idx];
         fall <= word_next[bit_idx + 4'd1];
      end
   end

endmodule

// File: rtl/ads5296_tx_emulator.sv
// rtl/ads5296_tx_emulator.sv - ADS5296 lane-pair TX emulator; ADS5296_TX_TESTPAT_EN adds test patterns
module ads5296_tx_emulator
   import ads5296_pkg::*;
#(
   parameter logic [WORD_W-1:0] IDLE_WORD = 10'h000
) (
   input  logic              lclk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data0,
   input  logic [WORD_W-1:0] s_data1,
   input  logic [1:0]        mode,
   output logic [1:0]        dout_rise,
   output logic [1:0]        dout_fall,
   output logic              fclk_rise,
   output logic              fclk_fall,
   output logic              word_start,
   output logic              underflow,
   input  logic              underflow_clr
);

   logic [2:0]        phase;
   logic [2:0]        phase_next;
   logic              load_slot;
   logic              data_mode;
   logic              accept;
   logic [WORD_W-1:0] fill_word;
   logic [WORD_W-1:0] word0;
   logic [WORD_W-1:0] word1;

   // Phase sequencing: phase 4 is the load slot, then wrap to 0.
   always_comb begin
      load_slot  = (phase == LOAD_PHASE);
      phase_next = load_slot ? 3'd0 : phase + 3'd1;
   end

`ifdef ADS5296_TX_TESTPAT_EN
   logic [WORD_W-1:0] ramp_cnt;

   // Pattern substitution; a disabled block still sends only the idle word.
   always_comb begin
      data_mode = (mode_e'(mode) == DATA);
      fill_word = IDLE_WORD;
      if (en) begin
         case (mode_e'(mode))
            RAMP:    fill_word = ramp_cnt;
            DESKEW:  fill_word = DESKEW_PATTERN;
            SYNC:    fill_word = SYNC_PATTERN;
            default: fill_word = IDLE_WORD;
         endcase
      end
   end

   // Ramp restarts from 0 whenever ramp mode is left; advances once per load slot.
   always_ff @(posedge lclk or negedge rst_n) begin
      if (!rst_n) begin
         ramp_cnt <= '0;
      end else if (mode_e'(mode) != RAMP) begin
         ramp_cnt <= '0;
      end else if (load_slot) begin
         ramp_cnt <= ramp_cnt + 10'd1;
      end
   end
`else
   logic unused_mode;
   assign unused_mode = ^mode;

   // Without test patterns the block is always in data mode.
   always_comb begin
      data_mode = 1'b1;
      fill_word = IDLE_WORD;
   end
`endif

   // Acceptance happens only at the load slot; s_ready depends on registered phase.
   always_comb begin
      s_ready = en & load_slot & data_mode;
      accept  = s_valid & s_ready;
      word0   = accept ? s_data0 : fill_word;
      word1   = accept ? s_data1 : fill_word;
   end

   // Free-running phase counter, word_start marker and sticky underflow (set beats clear).
   always_ff @(posedge lclk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= LOAD_PHASE;
         word_start <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         phase      <= phase_next;
         word_start <= load_slot;
         if (load_slot & en & data_mode & ~s_valid) begin
            underflow <= 1'b1;
         end else if (underflow_clr) begin
            underflow <= 1'b0;
         end
      end
   end

   ads5296_tx_lane #(.RESET_WORD(IDLE_WORD)) u_lane0 (
      .clk        (lclk),
      .rst_n      (rst_n),
      .phase_next (phase_next),
      .load       (load_slot),
      .load_word  (word0),
      .rise       (dout_rise[0]),
      .fall       (dout_fall[0])
   );

   ads5296_tx_lane #(.RESET_WORD(IDLE_WORD)) u_lane1 (
      .clk        (lclk),
      .rst_n      (rst_n),
      .phase_next (phase_next),
      .load       (load_slot),
      .load_word  (word1),
      .rise       (dout_rise[1]),
      .fall       (dout_fall[1])
   );

   ads5296_tx_lane #(.RESET_WORD(FCLK_PATTERN)) u_frame (
      .clk        (lclk),
      .rst_n      (rst_n),
      .phase_next (phase_next),
      .load       (load_slot),
      .load_word  (FCLK_PATTERN),
      .rise       (fclk_rise),
      .fall       (fclk_fall)
   );

endmodule
